// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: buffers host I2C commands in a FIFO and issues them
// one at a time to i2c_master, returning one response per command.
//   clk, rst_n          : clock, async active-low reset
//   cmd_*               : host command push (valid/ready)
//   rsp_*               : per-command response (valid/ready)
//   m_*                 : i2c_master start/addr/data/rw and status
//   fifo_count, idle    : queue occupancy and quiescent flag
module i2c_cmd_sequencer #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_rw,
  input  logic [6:0]               cmd_addr,
  input  logic [7:0]               cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_rw,
  output logic [7:0]               rsp_data,
  output logic                     rsp_ack_error,
  output logic                     rsp_timeout,
  output logic                     m_start,
  output logic [6:0]               m_addr,
  output logic [7:0]               m_data_in,
  output logic                     m_rw,
  input  logic [7:0]               m_data_out,
  input  logic                     m_ack_error,
  input  logic                     m_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     idle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [7:0]  TMO  = 8'(BUSY_TIMEOUT);

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } state_t;

  cmd_t        mem [DEPTH];
  cmd_t        head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0] count;
  logic        push;
  logic        pop;
  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [7:0]  tmo_inc;

  assign cmd_ready  = count < FULL;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (count != '0) && !m_busy;
  assign head       = mem[rptr];
  assign fifo_count = count;
  assign idle       = (state == IDLE) && (count == '0);
  assign tmo_inc    = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_rw, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      m_start       <= 1'b0;
      m_addr        <= '0;
      m_data_in     <= '0;
      m_rw          <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rw        <= 1'b0;
      rsp_data      <= '0;
      rsp_ack_error <= 1'b0;
      rsp_timeout   <= 1'b0;
    end else begin
      m_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            m_addr    <= head.addr;
            m_data_in <= head.data;
            m_rw      <= head.rw;
            m_start   <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (m_busy) begin
            state <= WAIT_DONE;
          end else begin
            tmo_cnt <= tmo_inc;
            if (tmo_inc == TMO) begin
              rsp_rw        <= m_rw;
              rsp_data      <= '0;
              rsp_ack_error <= 1'b0;
              rsp_timeout   <= 1'b1;
              rsp_valid     <= 1'b1;
              state         <= RESPOND;
            end
          end
        end
        WAIT_DONE: begin
          if (!m_busy) begin
            rsp_rw        <= m_rw;
            rsp_data      <= m_data_out;
            rsp_ack_error <= m_ack_error;
            rsp_timeout   <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: directed plus randomized bench for
// i2c_cmd_sequencer with a behavioural i2c_master model.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 255;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [6:0]    cmd_addr;
  logic [7:0]    cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_rw;
  logic [7:0]    rsp_data;
  logic          rsp_ack_error;
  logic          rsp_timeout;
  logic          m_start;
  logic [6:0]    m_addr;
  logic [7:0]    m_data_in;
  logic          m_rw;
  logic [7:0]    m_data_out;
  logic          m_ack_error;
  logic          m_busy;
  logic [CW-1:0] fifo_count;
  logic          idle;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(
    .DEPTH(DEPTH),
    .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rw(rsp_rw),
    .rsp_data(rsp_data),
    .rsp_ack_error(rsp_ack_error),
    .rsp_timeout(rsp_timeout),
    .m_start(m_start),
    .m_addr(m_addr),
    .m_data_in(m_data_in),
    .m_rw(m_rw),
    .m_data_out(m_data_out),
    .m_ack_error(m_ack_error),
    .m_busy(m_busy),
    .fifo_count(fifo_count),
    .idle(idle)
  );

  typedef struct {
    int         delay;
    int         hold;
    logic [7:0] data;
    logic       ack;
  } plan_t;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct {
    logic       rw;
    logic [7:0] data;
    logic       ack;
    logic       tmo;
  } rsp_t;

  plan_t plan_q[$];
  cmd_t  iss_q[$];
  rsp_t  exp_q[$];
  bit    mm_en = 1'b1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic plan_t rplan();
    plan_t p;
    p.delay = $urandom_range(0, 3);
    p.hold  = $urandom_range(1, 12);
    p.data  = 8'($urandom);
    p.ack   = 1'($urandom);
    return p;
  endfunction

  // Master model: busy rises a few cycles after start, lasts 'hold'
  // cycles, junk on data_out while busy, real result when it falls.
  initial begin : master
    plan_t cur;
    int    left;
    int    dly;
    bit    pend;
    m_busy      = 1'b0;
    m_data_out  = 8'h00;
    m_ack_error = 1'b0;
    pend = 1'b0;
    left = 0;
    dly  = 0;
    cur  = '{0, 0, 8'h00, 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0;
        pend   = 1'b0;
      end else if (m_busy) begin
        left--;
        if (left <= 0) begin
          m_busy      = 1'b0;
          m_data_out  = cur.data;
          m_ack_error = cur.ack;
        end else begin
          m_data_out  = 8'($urandom);
          m_ack_error = 1'($urandom);
        end
      end else if (pend) begin
        if (dly <= 0) begin
          m_busy = 1'b1;
          left   = cur.hold;
          pend   = 1'b0;
        end else begin
          dly--;
        end
      end else if (m_start && mm_en && plan_q.size() > 0) begin
        cur  = plan_q.pop_front();
        pend = 1'b1;
        dly  = cur.delay;
      end
    end
  end

  // Protocol monitor: start pulse shape and contents, master-side
  // hold, response latency, response stability and back-to-back issue.
  initial begin : monitor
    int          cyc;
    int          start_cyc;
    bit          prev_start, prev_rv, prev_busy, inflight, b2b;
    bit          rr_e, busy_e;
    logic [15:0] prev_m;
    logic [10:0] prev_r;
    cmd_t        c;
    cyc = 0;
    start_cyc = 0;
    prev_start = 0; prev_rv = 0; prev_busy = 0;
    inflight = 0; b2b = 0;
    prev_m = '0; prev_r = '0;
    forever begin
      @(posedge clk);
      rr_e   = rsp_ready;
      busy_e = m_busy;
      #1;
      cyc++;
      if (!rst_n) begin
        prev_start = 0; prev_rv = 0; prev_busy = 0;
        inflight = 0; b2b = 0;
      end else begin
        if (b2b) begin
          chk("b2b_start", m_start, 1);
          b2b = 0;
        end
        if (m_start) begin
          chk("start_one_cycle", prev_start, 0);
          if (!prev_start) begin
            chk("start_while_inflight", inflight, 0);
            chk("start_has_cmd", iss_q.size() > 0, 1);
            if (iss_q.size() > 0) begin
              c = iss_q.pop_front();
              chk("m_addr", m_addr, c.addr);
              chk("m_data_in", m_data_in, c.data);
              chk("m_rw", m_rw, c.rw);
            end
            start_cyc = cyc;
            inflight  = 1;
          end
        end
        if (busy_e && prev_busy)
          chk("m_hold", {m_rw, m_addr, m_data_in}, prev_m);
        if (prev_rv) begin
          if (rr_e) begin
            chk("rsp_drop", rsp_valid, 0);
            inflight = 0;
            b2b = (fifo_count != 0) && !m_busy;
          end else begin
            chk("rsp_held", rsp_valid, 1);
            chk("rsp_stable",
                {rsp_rw, rsp_data, rsp_ack_error, rsp_timeout}, prev_r);
          end
        end else if (rsp_valid) begin
          if (rsp_timeout) begin
            chk("tmo_latency", cyc - start_cyc, TMO + 1);
          end else begin
            chk("done_busy_low", busy_e, 0);
            chk("done_busy_was_high", prev_busy, 1);
          end
        end
        prev_start = m_start;
        prev_rv    = rsp_valid;
        prev_busy  = busy_e;
        prev_m     = {m_rw, m_addr, m_data_in};
        prev_r     = {rsp_rw, rsp_data, rsp_ack_error, rsp_timeout};
      end
    end
  end

  task automatic push(input logic rw, input logic [6:0] a,
                      input logic [7:0] d, input bit tmo,
                      input plan_t p);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && n < 500) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      chk("push_wait", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    step();
    cmd_valid = 1'b0;
    iss_q.push_back('{rw, a, d});
    if (tmo) begin
      exp_q.push_back('{rw, 8'h00, 1'b0, 1'b1});
    end else begin
      plan_q.push_back(p);
      exp_q.push_back('{rw, p.data, p.ack, 1'b0});
    end
  endtask

  task automatic expect_rsp(input int ready_delay);
    rsp_t e;
    int   n;
    n = 0;
    e = exp_q.pop_front();
    while (!rsp_valid && n < 2000) begin
      step();
      n++;
    end
    chk("rsp_arrive", rsp_valid, 1);
    if (!rsp_valid) return;
    for (int i = 0; i < ready_delay; i++) begin
      step();
      chk("bp_no_start", m_start, 0);
    end
    chk("rsp_rw", rsp_rw, e.rw);
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_ack_error", rsp_ack_error, e.ack);
    chk("rsp_timeout", rsp_timeout, e.tmo);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin : stim
    plan_t p;
    int    n;
    int    k;
    bit    seen_rv;
    bit    seen_st;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;

    repeat (2) step();
    chk("rst_m_start", m_start, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_data_in", m_data_in, 0);
    chk("rst_m_rw", m_rw, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields",
        {rsp_rw, rsp_data, rsp_ack_error, rsp_timeout}, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_idle", idle, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_idle", idle, 1);

    // single write with issue latency
    p = '{1, 20, 8'h77, 1'b0};
    push(1'b0, 7'h51, 8'hA5, 1'b0, p);
    chk("lat_n1_start", m_start, 0);
    step();
    chk("lat_n2_start", m_start, 1);
    chk("wr_m_addr", m_addr, 7'h51);
    chk("wr_m_data_in", m_data_in, 8'hA5);
    chk("wr_m_rw", m_rw, 0);
    step();
    chk("lat_n3_start", m_start, 0);
    expect_rsp(0);

    // read capture
    p = '{2, 8, 8'h3C, 1'b1};
    push(1'b1, 7'h51, 8'h00, 1'b0, p);
    expect_rsp(2);

    // full and ordering
    p = '{0, 60, 8'($urandom), 1'($urandom)};
    push(1'b0, 7'h10, 8'($urandom), 1'b0, p);
    n = 0;
    while (!m_busy && n < 50) begin
      step();
      n++;
    end
    chk("full_busy_rise", m_busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      push(1'($urandom), 7'($urandom), 8'($urandom), 1'b0, rplan());
      chk("fill_count", fifo_count, i + 1);
    end
    chk("full_ready", cmd_ready, 0);
    chk("peak_count", fifo_count, DEPTH);
    cmd_valid = 1'b1;
    cmd_rw    = 1'b1;
    cmd_addr  = 7'h6E;
    cmd_data  = 8'hE5;
    repeat (3) begin
      step();
      chk("full_hold_count", fifo_count, DEPTH);
    end
    fork
      push(1'b1, 7'h6E, 8'hE5, 1'b0, rplan());
      expect_rsp(0);
    join
    repeat (DEPTH + 1) expect_rsp($urandom_range(0, 2));
    chk("drain_exp_empty", exp_q.size(), 0);
    chk("drain_count", fifo_count, 0);
    step();
    chk("drain_idle", idle, 1);

    // timeout
    mm_en = 1'b0;
    push(1'b1, 7'h22, 8'h5C, 1'b1, p);
    expect_rsp(0);
    mm_en = 1'b1;

    // response backpressure
    push(1'b0, 7'h33, 8'h11, 1'b0, '{0, 5, 8'hC3, 1'b0});
    push(1'b1, 7'h44, 8'h22, 1'b0, '{1, 4, 8'h9A, 1'b1});
    expect_rsp(30);
    expect_rsp(0);

    // randomized bursts
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(1, DEPTH);
      for (int j = 0; j < k; j++)
        push(1'($urandom), 7'($urandom), 8'($urandom), 1'b0, rplan());
      for (int j = 0; j < k; j++)
        expect_rsp($urandom_range(0, 3));
    end
    chk("rand_exp_empty", exp_q.size(), 0);

    // reset mid-operation
    push(1'b0, 7'h01, 8'h01, 1'b0, '{0, 100, 8'h01, 1'b0});
    push(1'b0, 7'h02, 8'h02, 1'b0, rplan());
    push(1'b0, 7'h03, 8'h03, 1'b0, rplan());
    n = 0;
    while (!m_busy && n < 50) begin
      step();
      n++;
    end
    chk("mid_busy", m_busy, 1);
    chk("mid_count", fifo_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_start", m_start, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    plan_q.delete();
    exp_q.delete();
    iss_q.delete();
    repeat (3) step();
    @(posedge clk);
    #3 rst_n = 1'b1;
    seen_rv = 1'b0;
    seen_st = 1'b0;
    repeat (60) begin
      step();
      if (rsp_valid) seen_rv = 1'b1;
      if (m_start) seen_st = 1'b1;
    end
    chk("post_rst_no_rsp", seen_rv, 0);
    chk("post_rst_no_start", seen_st, 0);
    chk("post_rst_idle2", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Command-queue front end that sits directly upstream of `i2c_master`. It buffers host I2C transactions (rw, 7-bit address, data byte) in a small FIFO and issues them one at a time over the master's `start/addr/data_in/rw` interface. It tracks each transaction through the master's `busy` flag and returns one response per command (read data, ACK error, timeout) on a valid/ready channel, so software never has to handle the master's single-cycle start pulse directly.

## Interface
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `BUSY_TIMEOUT`, 255: cycles allowed for `m_busy` to rise after `m_start`; range 1..255.

- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  FIFO not full; a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_rw`  in  1  1 = read, 0 = write.
- `cmd_addr`  in  7  target address.
- `cmd_data`  in  8  write byte; ignored for reads but still stored.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  host takes the response.
- `rsp_rw`  out  1  rw of the completed command.
- `rsp_data`  out  8  `m_data_out` captured at completion; 0 for a timeout.
- `rsp_ack_error`  out  1  `m_ack_error` captured at completion.
- `rsp_timeout`  out  1  master never went busy.
- `m_start`  out  1  one-cycle start pulse to the master.
- `m_addr`  out  7  address to the master.
- `m_data_in`  out  8  write data to the master.
- `m_rw`  out  1  rw to the master.
- `m_data_out`  in  8  master read data.
- `m_ack_error`  in  1  master NACK flag.
- `m_busy`  in  1  master transaction in progress.
- `fifo_count`  out  $clog2(DEPTH)+1  entries currently queued.
- `idle`  out  1  FSM in IDLE and FIFO empty.

## Operation
- **FIFO**
  - Circular buffer with wrapping read/write pointers and a separate count.
  - `cmd_ready` = (count < DEPTH), combinational.
  - A push when full is ignored, even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves count unchanged.
- **FSM** (registered state; outputs are Moore):
  - IDLE: if count > 0 and !`m_busy`, latch the FIFO head into `m_addr/m_data_in/m_rw`, pop, and go to LAUNCH. If `m_busy` is high, wait.
  - LAUNCH: `m_start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_BUSY.
  - WAIT_BUSY:
    - If `m_busy`=1, go to WAIT_DONE.
    - Otherwise, increment the counter.
    - When the counter reaches BUSY_TIMEOUT, go to RESPOND with timeout=1, ack_error=0, data=0.
  - WAIT_DONE: on the first cycle `m_busy`=0, capture `m_data_out` and `m_ack_error`, set timeout=0, and go to RESPOND.
  - RESPOND: `rsp_valid`=1 and the `rsp_*` fields are held stable until `rsp_ready`. Then go to IDLE.
- `m_addr/m_data_in/m_rw` hold their latched values from LAUNCH until the next latch; they never change while `m_busy` is high.
- Commands may be pushed in any state. Responses complete in strict FIFO order, one per command.
- The timeout counter is 8 bits and saturates; it never wraps.

## Timing
- Reset (async assert, immediate): FIFO empty, pointers 0, FSM IDLE.
  - Outputs: `m_start`=0, `m_addr`=0, `m_data_in`=0, `m_rw`=0, `rsp_*`=0, `rsp_valid`=0, `fifo_count`=0, `cmd_ready`=1, `idle`=1.
- Reset mid-transaction: queued commands are discarded, no response is produced, and `m_start` drops in the same cycle.
- Issue latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE and `m_busy`=0 gives `m_start`=1 during cycle N+2 (state LAUNCH after edge N+1).
- Response latency: `m_busy` sampled low at edge K in WAIT_DONE gives `rsp_valid`=1 from edge K+1.
- Back-to-back throughput: after `rsp_ready` at edge R, the next `m_start` occurs in cycle R+2 (IDLE, then LAUNCH).
- Timeout: `rsp_valid` rises BUSY_TIMEOUT+1 cycles after the LAUNCH cycle when `m_busy` stays 0.
- `m_start` is never high for more than one consecutive cycle.

## Test plan
- **Single write:** push {rw=0, addr=7'h51, data=8'hA5} with the model master holding busy for 20 cycles and ack_error=0.
  - Expect `m_start` 1 cycle wide at N+2 and `m_addr`=7'h51, `m_data_in`=8'hA5.
  - Expect a response {rw=0, ack_error=0, timeout=0}.
- **Read capture:** push {rw=1, addr=7'h51} with the model returning `m_data_out`=8'h3C and ack_error=1.
  - Expect `rsp_data`=8'h3C, `rsp_ack_error`=1, `rsp_rw`=1.
- **Full/ordering:** push DEPTH+1 commands back-to-back while the master is busy.
  - Expect `cmd_ready`=0 after DEPTH accepts and `fifo_count` peaking at DEPTH.
  - After draining, expect responses in push order with no command lost.
- **Timeout:** tie `m_busy`=0 and push one command.
  - Expect `rsp_valid` exactly BUSY_TIMEOUT+1 cycles after `m_start`, with `rsp_timeout`=1 and `rsp_data`=0.
- **Response backpressure:** hold `rsp_ready`=0 for 30 cycles with a second command queued.
  - Expect the `rsp_*` fields stable and no second `m_start` until `rsp_ready` is asserted.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT_DONE with 2 commands queued.
  - Expect immediate `fifo_count`=0, `idle`=1, `m_start`=0, and no response after release.
